// File: rtl/sata_usr_responder.sv
// Stand-in for the SATA wrapper's user-side command/data ports: acknowledges
// {RW,len,addr} commands, checks write-stream framing and sources address-derived read data.
module sata_usr_responder #(
  parameter int unsigned ACK_DLY = 4
) (
  input  logic        usr_clk,
  input  logic        usr_rst,
  input  logic [71:0] usr_cmd,
  input  logic        usr_cmd_req,
  output logic        usr_cmd_ack,
  input  logic [31:0] s_aixs_usr_tdata,
  input  logic [7:0]  s_aixs_usr_tuser,
  input  logic        s_aixs_usr_tvalid,
  output logic        s_aixs_usr_tready,
  output logic [31:0] m_aixs_usr_tdata,
  output logic [7:0]  m_aixs_usr_tuser,
  output logic        m_aixs_usr_tvalid,
  input  logic        m_aixs_usr_tready,
  output logic [31:0] cmd_cnt,
  output logic [31:0] wr_beat_cnt,
  output logic [31:0] rd_beat_cnt,
  output logic [31:0] proto_err_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACK_WAIT, WR_DATA, RD_DATA} state_t;

  localparam logic [7:0] DLY_INIT = 8'(ACK_DLY - 1);

  state_t      state_q, state_d;
  logic        req_q;
  logic        rw_q, rw_d;
  logic [22:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  dly_q, dly_d;
  logic [22:0] idx_q, idx_d;
  logic        ack_q, ack_d;
  logic        s_tready_q, s_tready_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [31:0] m_tdata_q, m_tdata_d;
  logic [7:0]  m_tuser_q, m_tuser_d;
  logic [31:0] cmd_cnt_q, cmd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        busy_q, busy_d;
  logic [22:0] last_idx;
  logic        is_first, is_last, beat_sop, beat_eop;

  // Only tuser sop/eop and the low address word matter to this model.
  logic unused_ok;
  assign unused_ok = ^{usr_cmd[47:32], s_aixs_usr_tdata, s_aixs_usr_tuser[7:2]};

  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      dly_q      <= '0;
      idx_q      <= '0;
      ack_q      <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      cmd_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= usr_cmd_req;
      rw_q       <= rw_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      dly_q      <= dly_d;
      idx_q      <= idx_d;
      ack_q      <= ack_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      cmd_cnt_q  <= cmd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    len_d      = len_q;
    addr_d     = addr_q;
    dly_d      = dly_q;
    idx_d      = idx_q;
    ack_d      = 1'b0;
    s_tready_d = s_tready_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    cmd_cnt_d  = cmd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    err_cnt_d  = err_cnt_q;
    last_idx   = len_q - 23'd1;
    is_first   = (idx_q == 23'd0);
    is_last    = (idx_q == last_idx);
    beat_sop   = s_aixs_usr_tuser[1];
    beat_eop   = s_aixs_usr_tuser[0];

    unique case (state_q)
      IDLE: begin
        if (usr_cmd_req && !req_q) begin
          state_d   = ACK_WAIT;
          rw_d      = usr_cmd[71];
          len_d     = usr_cmd[70:48];
          addr_d    = usr_cmd[31:0];
          idx_d     = '0;
          cmd_cnt_d = cmd_cnt_q + 32'd1;
          dly_d     = DLY_INIT;
          ack_d     = (DLY_INIT == 8'd0);
        end
      end
      ACK_WAIT: begin
        // The ack pulse itself marks the last delay cycle; leave on the edge that ends it.
        if (ack_q) begin
          if (len_q == 23'd0) begin
            state_d   = IDLE;
            err_cnt_d = err_cnt_q + 32'd1;
          end else if (rw_q) begin
            state_d    = WR_DATA;
            s_tready_d = 1'b1;
          end else begin
            state_d    = RD_DATA;
            m_tvalid_d = 1'b1;
            m_tdata_d  = addr_q;
            m_tuser_d  = {2'b00, 4'hF, 1'b1, (len_q == 23'd1)};
          end
        end else begin
          dly_d = dly_q - 8'd1;
          ack_d = (dly_q == 8'd1);
        end
      end
      WR_DATA: begin
        if (s_aixs_usr_tvalid && s_tready_q) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
          idx_d    = idx_q + 23'd1;
          if ((beat_sop != is_first) || (beat_eop != is_last)) begin
            err_cnt_d = err_cnt_q + 32'd1;
          end
          if (beat_eop || is_last) begin
            state_d    = IDLE;
            s_tready_d = 1'b0;
          end
        end
      end
      RD_DATA: begin
        if (m_tvalid_q && m_aixs_usr_tready) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
          if (is_last) begin
            state_d    = IDLE;
            m_tvalid_d = 1'b0;
            m_tdata_d  = '0;
            m_tuser_d  = '0;
          end else begin
            idx_d     = idx_q + 23'd1;
            m_tdata_d = addr_q + 32'(idx_q) + 32'd1;
            m_tuser_d = {2'b00, 4'hF, 1'b0, ((idx_q + 23'd1) == last_idx)};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign usr_cmd_ack       = ack_q;
  assign s_aixs_usr_tready = s_tready_q;
  assign m_aixs_usr_tvalid = m_tvalid_q;
  assign m_aixs_usr_tdata  = m_tdata_q;
  assign m_aixs_usr_tuser  = m_tuser_q;
  assign cmd_cnt           = cmd_cnt_q;
  assign wr_beat_cnt       = wr_cnt_q;
  assign rd_beat_cnt       = rd_cnt_q;
  assign proto_err_cnt     = err_cnt_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_sata_usr_responder.sv
// Directed bench for sata_usr_responder: read beats are predicted into a queue
// when the command is issued and popped by a monitor at each handshake.
module tb_sata_usr_responder;

  localparam int ACK_DLY = 4;

  logic        usr_clk;
  logic        usr_rst;
  logic [71:0] usr_cmd;
  logic        usr_cmd_req;
  logic        usr_cmd_ack;
  logic [31:0] s_aixs_usr_tdata;
  logic [7:0]  s_aixs_usr_tuser;
  logic        s_aixs_usr_tvalid;
  logic        s_aixs_usr_tready;
  logic [31:0] m_aixs_usr_tdata;
  logic [7:0]  m_aixs_usr_tuser;
  logic        m_aixs_usr_tvalid;
  logic        m_aixs_usr_tready;
  logic [31:0] cmd_cnt;
  logic [31:0] wr_beat_cnt;
  logic [31:0] rd_beat_cnt;
  logic [31:0] proto_err_cnt;
  logic        busy;

  int nChecks = 0;
  int nFail   = 0;

  logic [39:0] rdExpect[$];
  bit          stalledPrev = 0;
  logic [39:0] stallData   = '0;

  sata_usr_responder #(.ACK_DLY(ACK_DLY)) dut (
    .usr_clk           (usr_clk),
    .usr_rst           (usr_rst),
    .usr_cmd           (usr_cmd),
    .usr_cmd_req       (usr_cmd_req),
    .usr_cmd_ack       (usr_cmd_ack),
    .s_aixs_usr_tdata  (s_aixs_usr_tdata),
    .s_aixs_usr_tuser  (s_aixs_usr_tuser),
    .s_aixs_usr_tvalid (s_aixs_usr_tvalid),
    .s_aixs_usr_tready (s_aixs_usr_tready),
    .m_aixs_usr_tdata  (m_aixs_usr_tdata),
    .m_aixs_usr_tuser  (m_aixs_usr_tuser),
    .m_aixs_usr_tvalid (m_aixs_usr_tvalid),
    .m_aixs_usr_tready (m_aixs_usr_tready),
    .cmd_cnt           (cmd_cnt),
    .wr_beat_cnt       (wr_beat_cnt),
    .rd_beat_cnt       (rd_beat_cnt),
    .proto_err_cnt     (proto_err_cnt),
    .busy              (busy)
  );

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge usr_clk);
    #1;
  endtask

  // Read beats complete on the posedge after a negedge that sees valid&ready;
  // a stalled beat must still be present, unchanged, one cycle later.
  always @(negedge usr_clk) begin
    if (usr_rst) begin
      stalledPrev = 0;
    end else begin
      if (stalledPrev) begin
        checkVal("rd_stall_hold", {m_aixs_usr_tvalid, m_aixs_usr_tdata, m_aixs_usr_tuser}, {1'b1, stallData});
      end
      if (m_aixs_usr_tvalid && m_aixs_usr_tready) begin
        if (rdExpect.size() == 0) begin
          checkVal("rd_unexpected_beat", rdExpect.size(), 1);
        end else begin
          checkVal("rd_beat", {m_aixs_usr_tdata, m_aixs_usr_tuser}, rdExpect.pop_front());
        end
      end
      stalledPrev = m_aixs_usr_tvalid && !m_aixs_usr_tready;
      stallData   = {m_aixs_usr_tdata, m_aixs_usr_tuser};
    end
  end

  task automatic applyStimulus(input logic rw, input logic [22:0] len, input logic [31:0] addr,
                               input bit hold);
    int ackTicks;
    usr_cmd = {rw, len, 16'h0000, addr};
    if (!rw) begin
      for (int i = 0; i < int'(len); i++) begin
        rdExpect.push_back({addr + 32'(i), 2'b00, 4'hF, (i == 0), (i == int'(len) - 1)});
      end
    end
    usr_cmd_req = 1'b1;
    tick();
    checkVal("busy_on_accept", busy, 1);
    ackTicks = 0;
    while (!usr_cmd_ack && ackTicks < 300) begin
      tick();
      ackTicks++;
    end
    checkVal("ack_seen", usr_cmd_ack, 1);
    checkVal("ack_delay", ackTicks, ACK_DLY - 1);
    if (!hold) usr_cmd_req = 1'b0;
  endtask

  task automatic waitIdle(input bit toggleReady, output int n);
    n = 0;
    while (busy && n < 200) begin
      if (toggleReady) m_aixs_usr_tready = ~m_aixs_usr_tready;
      tick();
      n++;
    end
    checkVal("idle_reached", busy, 0);
  endtask

  task automatic sendWrite(input int nBeats, input logic [7:0] sopMask, input logic [7:0] eopMask,
                           output int readyCycles);
    readyCycles = 0;
    for (int k = 0; k < nBeats; k++) begin
      int guard;
      bit taken;
      guard = 0;
      taken = 0;
      s_aixs_usr_tvalid = 1'b1;
      s_aixs_usr_tdata  = 32'hA000 + 32'(k);
      s_aixs_usr_tuser  = {2'b00, 4'hF, sopMask[k], eopMask[k]};
      while (!taken && guard < 20) begin
        taken = s_aixs_usr_tready;
        if (taken) readyCycles++;
        tick();
        guard++;
      end
      checkVal("wr_beat_taken", taken, 1);
    end
    s_aixs_usr_tvalid = 1'b0;
    s_aixs_usr_tuser  = '0;
    checkVal("wr_tready_drop", s_aixs_usr_tready, 0);
    checkVal("wr_busy_drop", busy, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expCmd, input logic [31:0] expWr,
                             input logic [31:0] expRd, input logic [31:0] expErr);
    checkVal({tag, "_cmd_cnt"}, cmd_cnt, expCmd);
    checkVal({tag, "_wr_beat_cnt"}, wr_beat_cnt, expWr);
    checkVal({tag, "_rd_beat_cnt"}, rd_beat_cnt, expRd);
    checkVal({tag, "_proto_err_cnt"}, proto_err_cnt, expErr);
  endtask

  initial begin
    int n;
    int rc;
    int ackCount;

    usr_rst           = 1'b1;
    usr_cmd           = '0;
    usr_cmd_req       = 1'b0;
    s_aixs_usr_tdata  = '0;
    s_aixs_usr_tuser  = '0;
    s_aixs_usr_tvalid = 1'b0;
    m_aixs_usr_tready = 1'b0;
    repeat (3) tick();

    checkVal("rst_ack", usr_cmd_ack, 0);
    checkVal("rst_s_tready", s_aixs_usr_tready, 0);
    checkVal("rst_m_tvalid", m_aixs_usr_tvalid, 0);
    checkVal("rst_m_tdata", m_aixs_usr_tdata, 0);
    checkVal("rst_m_tuser", m_aixs_usr_tuser, 0);
    checkVal("rst_busy", busy, 0);
    checkOutput("rst", 0, 0, 0, 0);
    usr_rst = 1'b0;
    tick();

    // Read 4 beats from 0x1000 with a always-ready sink.
    m_aixs_usr_tready = 1'b1;
    applyStimulus(1'b0, 23'd4, 32'h0000_1000, 1'b0);
    tick();
    checkVal("rd1_ack_pulse", usr_cmd_ack, 0);
    waitIdle(1'b0, n);
    checkVal("rd1_cycles_to_idle", n + 1, 5);
    checkVal("rd1_queue_empty", rdExpect.size(), 0);
    checkOutput("rd1", 1, 0, 4, 0);

    // Read 3 beats with the sink alternating ready.
    applyStimulus(1'b0, 23'd3, 32'h0000_2000, 1'b0);
    waitIdle(1'b1, n);
    m_aixs_usr_tready = 1'b1;
    tick();
    checkVal("rd2_queue_empty", rdExpect.size(), 0);
    checkVal("rd2_tvalid_low", m_aixs_usr_tvalid, 0);
    checkOutput("rd2", 2, 0, 7, 0);

    // Well-framed write of 4 beats.
    applyStimulus(1'b1, 23'd4, 32'h0000_3000, 1'b0);
    sendWrite(4, 8'b0000_0001, 8'b0000_1000, rc);
    checkVal("wr1_ready_beats", rc, 4);
    tick();
    checkVal("wr1_tready_stays_low", s_aixs_usr_tready, 0);
    checkOutput("wr1", 3, 4, 7, 0);

    // Early eop on beat 1 of 4 ends the transfer there.
    applyStimulus(1'b1, 23'd4, 32'h0000_4000, 1'b0);
    sendWrite(2, 8'b0000_0001, 8'b0000_0010, rc);
    checkOutput("wr2", 4, 6, 7, 1);

    // Missing sop on beat 0.
    applyStimulus(1'b1, 23'd4, 32'h0000_5000, 1'b0);
    sendWrite(4, 8'b0000_0000, 8'b0000_1000, rc);
    checkOutput("wr3", 5, 10, 7, 2);

    // Missing eop on the last beat of a 2-beat write still ends after beat 1.
    applyStimulus(1'b1, 23'd2, 32'h0000_6000, 1'b0);
    sendWrite(2, 8'b0000_0001, 8'b0000_0000, rc);
    checkOutput("wr4", 6, 12, 7, 3);

    // Zero-length command with the request held high afterwards.
    applyStimulus(1'b0, 23'd0, 32'h0000_7000, 1'b1);
    tick();
    checkVal("len0_idle", busy, 0);
    ackCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (usr_cmd_ack) ackCount++;
      tick();
    end
    checkVal("held_req_no_ack", ackCount, 0);
    checkVal("held_req_idle", busy, 0);
    checkVal("held_req_tvalid", m_aixs_usr_tvalid, 0);
    checkOutput("held", 7, 12, 7, 4);
    usr_cmd_req = 1'b0;
    tick();

    // Reset while beat 2 of an 8-beat read is on the bus.
    applyStimulus(1'b0, 23'd8, 32'h0000_8000, 1'b0);
    n = 0;
    while (rd_beat_cnt != 32'd9 && n < 50) begin
      tick();
      n++;
    end
    checkVal("mid_rd_beat2_data", m_aixs_usr_tdata, 32'h0000_8002);
    usr_rst = 1'b1;
    #1;
    checkVal("mid_rst_tvalid", m_aixs_usr_tvalid, 0);
    checkVal("mid_rst_busy", busy, 0);
    checkOutput("mid_rst", 0, 0, 0, 0);
    rdExpect.delete();
    tick();
    tick();
    usr_rst = 1'b0;
    repeat (3) tick();
    checkVal("post_rst_ack", usr_cmd_ack, 0);
    checkVal("post_rst_tvalid", m_aixs_usr_tvalid, 0);
    checkOutput("post_rst", 0, 0, 0, 0);

    // Fresh command after reset, with read data wrapping past 0xFFFFFFFF.
    applyStimulus(1'b0, 23'd3, 32'hFFFF_FFFE, 1'b0);
    waitIdle(1'b0, n);
    tick();
    checkVal("wrap_queue_empty", rdExpect.size(), 0);
    checkOutput("wrap", 1, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/sata_usr_responder.md
# sata_usr_responder

Synthesizable stand-in for the SATA wrapper's user-side command/data interface, used to exercise `sata_bist` and other initiators without a GTX link or disk attached. It accepts `{RW,len,addr}` commands on the req/ack interface. For writes it sinks and checks the AXIS write stream; for reads it sources a deterministic, address-derived AXIS read stream. It sits on the user clock domain, in place of the wrapper's user ports.

## Interface
- `ACK_DLY`, default 4: cycles from command acceptance to the `usr_cmd_ack` pulse; legal range 1..255.
- `usr_clk`  in  1: user clock.
- `usr_rst`  in  1: asynchronous, active-high reset.
- `usr_cmd`  in  72: {RW[71], len[70:48] (dwords), addr[47:0]}; RW=1 write, 0 read.
- `usr_cmd_req`  in  1: command request, level, held by initiator until ack.
- `usr_cmd_ack`  out  1: one-cycle acknowledge pulse.
- `s_aixs_usr_tdata/tuser/tvalid/tready`  in/in/in/out  32/8/1/1: write data sink. tuser = {drop,err,keep[3:0],sop,eop}.
- `m_aixs_usr_tdata/tuser/tvalid/tready`  out/out/out/in  32/8/1/1: read data source, same tuser layout.
- `cmd_cnt`  out  32: commands accepted.
- `wr_beat_cnt`  out  32: write beats accepted.
- `rd_beat_cnt`  out  32: read beats delivered.
- `proto_err_cnt`  out  32: write-stream framing errors plus zero-length commands.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, ACK_WAIT, WR_DATA, RD_DATA.
- **IDLE:** a command is accepted on a rising edge of `usr_cmd_req` (req=1, registered req_d=0).
  - On acceptance: latch `usr_cmd`, increment `cmd_cnt`, load the delay counter with ACK_DLY, go to ACK_WAIT.
  - A req held high across returning to IDLE is not re-accepted.
- **ACK_WAIT:** count down. At zero, pulse `usr_cmd_ack` for one cycle, then:
  - len=0: `proto_err_cnt`+1, go to IDLE.
  - RW=1: go to WR_DATA.
  - RW=0: go to RD_DATA.
- **WR_DATA:**
  - `s_aixs_usr_tready`=1 only in this state. Each accepted beat (valid&ready) increments the 23-bit beat index and `wr_beat_cnt`.
  - Beat 0 must have sop=1. Beat len-1 must have eop=1. No other beat may carry sop or eop.
  - Each violating beat adds 1 to `proto_err_cnt`. A beat violating two rules still adds only 1.
  - Exit to IDLE on the first accepted beat with eop=1 or on beat len-1, whichever comes first. An early eop terminates the transfer.
  - tdata, keep, err and drop are ignored.
- **RD_DATA:**
  - Beat i: tdata = addr[31:0] + i (mod 2^32), tuser = {0,0,4'hF, sop=(i==0), eop=(i==len-1)}.
  - AXIS rule: once tvalid is high, tdata, tuser and tvalid hold until tready; tvalid never drops before the transfer completes.
  - Each handshake increments `rd_beat_cnt`. After the eop beat completes, go to IDLE.
- All counters are 32-bit and wrap from 0xFFFFFFFF to 0. Beat index width is 23 bits (max len 0x7FFFFF).

## Timing
- Reset (async assert, deassert sync to usr_clk), all outputs:
  - ack=0, both tready/tvalid=0, tdata=0, tuser=0, busy=0.
  - All counters 0, state IDLE, req_d=0.
- Reset mid-transfer: the transfer is abandoned immediately. No ack, beats, or counter updates are produced afterward.
- Command timing: request accepted at edge E, `busy`=1 from E. `usr_cmd_ack` is high for the cycle following edge E+ACK_DLY-1, so ACK_DLY=1 gives ack in the cycle right after acceptance.
- Read: the first tvalid asserts in the cycle after the ack cycle. With tready held high, one beat per cycle and len+1 cycles from ack to IDLE.
- Write: tready rises in the cycle after the ack cycle and is throughput-1. It drops in the cycle after the terminating beat.
- Registered outputs only; `usr_cmd` and tuser inputs are not sampled outside their defined phases.

## Test plan
- Read, addr=0x1000, len=4, ACK_DLY=4, tready=1:
  - ack exactly 4 cycles after acceptance.
  - tdata 0x1000..0x1003; sop on beat 0, eop on beat 3, keep=F.
  - rd_beat_cnt=4, cmd_cnt=1.
- Read, len=3, tready toggling 1010…: tdata/tuser are stable while stalled, no beat is dropped or duplicated, and tvalid stays high until the eop handshake.
- Write, len=4, correct framing: tready is high for exactly 4 beats, wr_beat_cnt=4, proto_err_cnt=0, and busy falls after beat 3.
- Write framing errors, each giving proto_err_cnt=1:
  - len=4 with eop on beat 1: transfer ends after beat 1.
  - len=4 with no sop on beat 0.
  - len=2 with eop missing on beat 1: transfer still ends after beat 1.
- len=0 command: a single ack pulse, no data, proto_err_cnt=1, back to IDLE.
- Held and interrupted requests:
  - req held high after ack through IDLE: no second acceptance, cmd_cnt stays 1.
  - usr_rst pulsed during read beat 2 of 8: tvalid=0 immediately, all counters 0, state IDLE, and the next req rising edge is accepted normally.
